ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-selection stage of the RV32I pipeline, sitting directly upstream of the ALU.
- Captures decoded fields from ID and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, inserts bubbles and squashes on branch flush.
- Drives the ALU operand1/operand2/alu_op inputs and the EX/MEM control fields.

---
 rtl/rv32_pkg.sv | 41 ++++
 rtl/ex_operand_stage_if.sv | 36 +++
 rtl/ex_hazard_unit.sv | 50 +++++
 rtl/ex_operand_stage.sv | 171 +++++++++++++++++
 tb/tb_ex_operand_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types: datapath widths, ALU op encodings,
// operand-select encodings and forwarding-source selection.
package rv32_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_e;

   // ADD is encoded as zero so a reset/bubble stage is all-zero registers.
   localparam logic [3:0] NOP_ALU_OP = ALU_ADD;

   typedef enum logic {OP1_RS1 = 1'b0, OP1_PC  = 1'b1} op1_sel_e;
   typedef enum logic {OP2_RS2 = 1'b0, OP2_IMM = 1'b1} op2_sel_e;

   typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

   // MEM beats WB; x0 is never a forwarding target.
   function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] rs,
                                           input logic              mem_wren,
                                           input logic [REG_AW-1:0] mem_rd,
                                           input logic              wb_wren,
                                           input logic [REG_AW-1:0] wb_rd);
      if (rs != '0 && mem_wren && mem_rd == rs) return FWD_MEM;
      if (rs != '0 && wb_wren && wb_rd == rs)   return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID -> EX decoded-instruction bundle. master = ID stage, slave = EX stage.
interface ex_operand_stage_if;
   import rv32_pkg::*;

   logic              id_valid_i;
   logic [XLEN-1:0]   id_pc_i;
   logic [REG_AW-1:0] id_rs1_addr_i;
   logic [REG_AW-1:0] id_rs2_addr_i;
   logic [XLEN-1:0]   id_rs1_data_i;
   logic [XLEN-1:0]   id_rs2_data_i;
   logic              id_use_rs1_i;
   logic              id_use_rs2_i;
   logic [XLEN-1:0]   id_imm_i;
   logic [3:0]        id_alu_op_i;
   logic              id_op1_sel_i;
   logic              id_op2_sel_i;
   logic [REG_AW-1:0] id_rd_addr_i;
   logic              id_rd_wren_i;
   logic              id_mem_rden_i;
   logic              id_mem_wren_i;

   modport master (
      output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_data_i,
             id_rs2_data_i, id_use_rs1_i, id_use_rs2_i, id_imm_i, id_alu_op_i,
             id_op1_sel_i, id_op2_sel_i, id_rd_addr_i, id_rd_wren_i,
             id_mem_rden_i, id_mem_wren_i
   );

   modport slave (
      input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_data_i,
             id_rs2_data_i, id_use_rs1_i, id_use_rs2_i, id_imm_i, id_alu_op_i,
             id_op1_sel_i, id_op2_sel_i, id_rd_addr_i, id_rd_wren_i,
             id_mem_rden_i, id_mem_wren_i
   );

endinterface

// File: rtl/ex_hazard_unit.sv
// Combinational stall detection for the EX operand stage.
// EX_FWD_EN defined: only load-use in EX stalls (MEM/WB forwarding covers the rest).
// EX_FWD_EN undefined: any pending write in EX or MEM to a used source stalls.
module ex_hazard_unit
   import rv32_pkg::*;
(
   input  logic              ex_valid_i,
   input  logic              ex_mem_rden_i,
   input  logic              ex_rd_wren_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              mem_rd_wren_i,
   input  logic [REG_AW-1:0] mem_rd_addr_i,
   input  logic              id_valid_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic              flush_i,
   output logic              stall_o
);

   logic ex_dep;
   logic hazard;

   assign ex_dep = (id_use_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
                   (id_use_rs2_i && id_rs2_addr_i == ex_rd_addr_i);

`ifdef EX_FWD_EN
   logic hz_unused;
   assign hz_unused = ^{ex_rd_wren_i, mem_rd_wren_i, mem_rd_addr_i};

   assign hazard = ex_valid_i && ex_mem_rden_i && ex_rd_addr_i != '0 &&
                   id_valid_i && ex_dep;
`else
   logic mem_dep;
   logic hz_unused;
   assign hz_unused = ex_mem_rden_i;

   assign mem_dep = (id_use_rs1_i && id_rs1_addr_i == mem_rd_addr_i) ||
                    (id_use_rs2_i && id_rs2_addr_i == mem_rd_addr_i);

   assign hazard = id_valid_i &&
                   ((ex_valid_i && ex_rd_wren_i && ex_rd_addr_i != '0 && ex_dep) ||
                    (mem_rd_wren_i && mem_rd_addr_i != '0 && mem_dep));
`endif

   // A flushed instruction never needs to wait.
   assign stall_o = hazard && !flush_i;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand selection for the RV32I core.
// Build option EX_FWD_EN enables MEM/WB operand forwarding; without it the
// hazard unit stalls until the producer reaches WB and the capture bypass
// supplies the value.
module ex_operand_stage
   import rv32_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   ex_operand_stage_if.slave id,
   input  logic [REG_AW-1:0] mem_rd_addr_i,
   input  logic              mem_rd_wren_i,
   input  logic [XLEN-1:0]   mem_alu_data_i,
   input  logic [REG_AW-1:0] wb_rd_addr_i,
   input  logic              wb_rd_wren_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic              stall_o,
   output logic              ex_valid_o,
   output logic [XLEN-1:0]   operand1_o,
   output logic [XLEN-1:0]   operand2_o,
   output logic [3:0]        alu_op_o,
   output logic [XLEN-1:0]   ex_store_data_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [REG_AW-1:0] ex_rd_addr_o,
   output logic              ex_rd_wren_o,
   output logic              ex_mem_rden_o,
   output logic              ex_mem_wren_o
);

   logic              valid_q,    valid_d;
   logic [XLEN-1:0]   pc_q,       pc_d;
   logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]   imm_q,      imm_d;
   logic [3:0]        alu_op_q,   alu_op_d;
   logic              op1_sel_q,  op1_sel_d;
   logic              op2_sel_q,  op2_sel_d;
   logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
   logic              rd_wren_q,  rd_wren_d;
   logic              mem_rden_q, mem_rden_d;
   logic              mem_wren_q, mem_wren_d;

   logic              bubble;
   logic [XLEN-1:0]   fwd_rs1;
   logic [XLEN-1:0]   fwd_rs2;

   ex_hazard_unit u_hazard (
      .ex_valid_i    (valid_q),
      .ex_mem_rden_i (mem_rden_q),
      .ex_rd_wren_i  (rd_wren_q),
      .ex_rd_addr_i  (rd_addr_q),
      .mem_rd_wren_i (mem_rd_wren_i),
      .mem_rd_addr_i (mem_rd_addr_i),
      .id_valid_i    (id.id_valid_i),
      .id_use_rs1_i  (id.id_use_rs1_i),
      .id_use_rs2_i  (id.id_use_rs2_i),
      .id_rs1_addr_i (id.id_rs1_addr_i),
      .id_rs2_addr_i (id.id_rs2_addr_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o)
   );

   assign bubble = flush_i || stall_o;

   // Next-state: capture ID (with WB bypass on read data), or insert a bubble.
   always_comb begin
      pc_d       = id.id_pc_i;
      rs1_addr_d = id.id_rs1_addr_i;
      rs2_addr_d = id.id_rs2_addr_i;
      imm_d      = id.id_imm_i;
      op1_sel_d  = id.id_op1_sel_i;
      op2_sel_d  = id.id_op2_sel_i;
      rd_addr_d  = id.id_rd_addr_i;
      rs1_data_d = (fwd_select(id.id_rs1_addr_i, 1'b0, '0, wb_rd_wren_i, wb_rd_addr_i) == FWD_WB)
                   ? wb_data_i : id.id_rs1_data_i;
      rs2_data_d = (fwd_select(id.id_rs2_addr_i, 1'b0, '0, wb_rd_wren_i, wb_rd_addr_i) == FWD_WB)
                   ? wb_data_i : id.id_rs2_data_i;
      valid_d    = id.id_valid_i;
      alu_op_d   = id.id_valid_i ? id.id_alu_op_i : NOP_ALU_OP;
      rd_wren_d  = id.id_valid_i && id.id_rd_wren_i;
      mem_rden_d = id.id_valid_i && id.id_mem_rden_i;
      mem_wren_d = id.id_valid_i && id.id_mem_wren_i;
      if (bubble) begin
         valid_d    = 1'b0;
         alu_op_d   = NOP_ALU_OP;
         rd_wren_d  = 1'b0;
         mem_rden_d = 1'b0;
         mem_wren_d = 1'b0;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alu_op_q   <= NOP_ALU_OP;
         op1_sel_q  <= 1'b0;
         op2_sel_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_wren_q  <= 1'b0;
         mem_rden_q <= 1'b0;
         mem_wren_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         alu_op_q   <= alu_op_d;
         op1_sel_q  <= op1_sel_d;
         op2_sel_q  <= op2_sel_d;
         rd_addr_q  <= rd_addr_d;
         rd_wren_q  <= rd_wren_d;
         mem_rden_q <= mem_rden_d;
         mem_wren_q <= mem_wren_d;
      end
   end

`ifdef EX_FWD_EN
   fwd_sel_e rs1_sel;
   fwd_sel_e rs2_sel;

   assign rs1_sel = fwd_select(rs1_addr_q, mem_rd_wren_i, mem_rd_addr_i, wb_rd_wren_i, wb_rd_addr_i);
   assign rs2_sel = fwd_select(rs2_addr_q, mem_rd_wren_i, mem_rd_addr_i, wb_rd_wren_i, wb_rd_addr_i);

   // Forwarding muxes on the registered source operands.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      fwd_rs2 = rs2_data_q;
      case (rs1_sel)
         FWD_MEM: fwd_rs1 = mem_alu_data_i;
         FWD_WB:  fwd_rs1 = wb_data_i;
         default: fwd_rs1 = rs1_data_q;
      endcase
      case (rs2_sel)
         FWD_MEM: fwd_rs2 = mem_alu_data_i;
         FWD_WB:  fwd_rs2 = wb_data_i;
         default: fwd_rs2 = rs2_data_q;
      endcase
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^{mem_alu_data_i, rs1_addr_q, rs2_addr_q};

   assign fwd_rs1 = rs1_data_q;
   assign fwd_rs2 = rs2_data_q;
`endif

   assign operand1_o      = (op1_sel_q == OP1_PC)  ? pc_q  : fwd_rs1;
   assign operand2_o      = (op2_sel_q == OP2_IMM) ? imm_q : fwd_rs2;
   assign ex_store_data_o = fwd_rs2;
   assign ex_valid_o      = valid_q;
   assign alu_op_o        = valid_q ? alu_op_q : NOP_ALU_OP;
   assign ex_pc_o         = pc_q;
   assign ex_rd_addr_o    = rd_addr_q;
   assign ex_rd_wren_o    = valid_q && rd_wren_q;
   assign ex_mem_rden_o   = valid_q && mem_rden_q;
   assign ex_mem_wren_o   = valid_q && mem_wren_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow the EX_FWD_EN build option.
module tb_ex_operand_stage;
   import rv32_pkg::*;

`ifdef EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic [REG_AW-1:0] mem_rd_addr_i;
   logic              mem_rd_wren_i;
   logic [XLEN-1:0]   mem_alu_data_i;
   logic [REG_AW-1:0] wb_rd_addr_i;
   logic              wb_rd_wren_i;
   logic [XLEN-1:0]   wb_data_i;
   logic              stall_o;
   logic              ex_valid_o;
   logic [XLEN-1:0]   operand1_o;
   logic [XLEN-1:0]   operand2_o;
   logic [3:0]        alu_op_o;
   logic [XLEN-1:0]   ex_store_data_o;
   logic [XLEN-1:0]   ex_pc_o;
   logic [REG_AW-1:0] ex_rd_addr_o;
   logic              ex_rd_wren_o;
   logic              ex_mem_rden_o;
   logic              ex_mem_wren_o;

   int checks   = 0;
   int failures = 0;

   ex_operand_stage_if id_if ();

   ex_operand_stage dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .id              (id_if),
      .mem_rd_addr_i   (mem_rd_addr_i),
      .mem_rd_wren_i   (mem_rd_wren_i),
      .mem_alu_data_i  (mem_alu_data_i),
      .wb_rd_addr_i    (wb_rd_addr_i),
      .wb_rd_wren_i    (wb_rd_wren_i),
      .wb_data_i       (wb_data_i),
      .stall_o         (stall_o),
      .ex_valid_o      (ex_valid_o),
      .operand1_o      (operand1_o),
      .operand2_o      (operand2_o),
      .alu_op_o        (alu_op_o),
      .ex_store_data_o (ex_store_data_o),
      .ex_pc_o         (ex_pc_o),
      .ex_rd_addr_o    (ex_rd_addr_o),
      .ex_rd_wren_o    (ex_rd_wren_o),
      .ex_mem_rden_o   (ex_mem_rden_o),
      .ex_mem_wren_o   (ex_mem_wren_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic u1, input logic u2, input logic [31:0] imm,
                           input logic [3:0] op, input logic s1, input logic s2,
                           input logic [4:0] rd, input logic wr,
                           input logic rden, input logic mwren);
      id_if.id_valid_i    = v;
      id_if.id_pc_i       = pc;
      id_if.id_rs1_addr_i = rs1;
      id_if.id_rs2_addr_i = rs2;
      id_if.id_rs1_data_i = d1;
      id_if.id_rs2_data_i = d2;
      id_if.id_use_rs1_i  = u1;
      id_if.id_use_rs2_i  = u2;
      id_if.id_imm_i      = imm;
      id_if.id_alu_op_i   = op;
      id_if.id_op1_sel_i  = s1;
      id_if.id_op2_sel_i  = s2;
      id_if.id_rd_addr_i  = rd;
      id_if.id_rd_wren_i  = wr;
      id_if.id_mem_rden_i = rden;
      id_if.id_mem_wren_i = mwren;
   endtask

   task automatic id_idle();
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic set_mem(input logic w, input logic [4:0] a, input logic [31:0] d);
      mem_rd_wren_i = w; mem_rd_addr_i = a; mem_alu_data_i = d;
   endtask

   task automatic set_wb(input logic w, input logic [4:0] a, input logic [31:0] d);
      wb_rd_wren_i = w; wb_rd_addr_i = a; wb_data_i = d;
   endtask

   initial begin
      rst_i   = 1'b1;
      flush_i = 1'b0;
      id_idle();
      set_mem(0, 0, 0);
      set_wb(0, 0, 0);
      repeat (2) tick();
      chk("rst_valid",  {31'd0, ex_valid_o}, 32'd0);
      chk("rst_aluop",  {28'd0, alu_op_o}, 32'd0);
      chk("rst_rdwren", {31'd0, ex_rd_wren_o}, 32'd0);
      chk("rst_op1",    operand1_o, 32'd0);
      chk("rst_stall",  {31'd0, stall_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Plain capture: ADD x1 = x5 + x6
      drive_id(1, 32'h100, 5, 6, 32'd10, 32'd20, 1, 1, 0, ALU_ADD, 0, 0, 1, 1, 0, 0);
      tick();
      chk("cap_valid", {31'd0, ex_valid_o}, 32'd1);
      chk("cap_op1",   operand1_o, 32'd10);
      chk("cap_op2",   operand2_o, 32'd20);
      chk("cap_pc",    ex_pc_o, 32'h100);
      chk("cap_rd",    {27'd0, ex_rd_addr_o}, 32'd1);
      chk("cap_rdwr",  {31'd0, ex_rd_wren_o}, 32'd1);

      // PC/imm operand select with a store of x7
      drive_id(1, 32'h200, 0, 7, 32'd0, 32'h33, 0, 1, 32'h1000, ALU_SUB, 1, 1, 0, 0, 0, 1);
      tick();
      chk("sel_op1",   operand1_o, 32'h200);
      chk("sel_op2",   operand2_o, 32'h1000);
      chk("sel_st",    ex_store_data_o, 32'h33);
      chk("sel_aluop", {28'd0, alu_op_o}, {28'd0, ALU_SUB});
      chk("sel_mwr",   {31'd0, ex_mem_wren_o}, 32'd1);
      chk("sel_rdwr",  {31'd0, ex_rd_wren_o}, 32'd0);

      // Capture bypass: WB writes x8 during capture, RF value is stale
      drive_id(1, 32'h204, 8, 0, 32'd1, 32'd0, 1, 0, 0, ALU_ADD, 0, 0, 9, 1, 0, 0);
      set_wb(1, 8, 32'hABCD);
      tick();
      set_wb(0, 0, 0);
      id_idle();
      #1 chk("bypass_op1", operand1_o, 32'hABCD);

      // ADD x2 = x1 + x1 with x1 produced in MEM (=5)
      drive_id(1, 32'h208, 1, 1, 32'd11, 32'd12, 1, 1, 0, ALU_ADD, 0, 0, 2, 1, 0, 0);
      tick();
      id_idle();
      set_mem(1, 1, 32'd5);
      #1;
      chk("fmem_op1",  operand1_o, FWD ? 32'd5 : 32'd11);
      chk("fmem_op2",  operand2_o, FWD ? 32'd5 : 32'd12);
      chk("fmem_stall", {31'd0, stall_o}, 32'd0);
      set_mem(0, 0, 0);

      // MEM and WB both write x3: MEM wins, then WB alone
      drive_id(1, 32'h20C, 3, 0, 32'd1, 32'd0, 1, 0, 0, ALU_ADD, 0, 0, 4, 1, 0, 0);
      tick();
      id_idle();
      set_mem(1, 3, 32'd7);
      set_wb(1, 3, 32'd9);
      #1 chk("fprio_op1", operand1_o, FWD ? 32'd7 : 32'd1);
      set_mem(0, 0, 0);
      #1 chk("fwb_op1", operand1_o, FWD ? 32'd9 : 32'd1);
      set_wb(0, 0, 0);

      // x0 is never forwarded
      drive_id(1, 32'h210, 0, 0, 32'd0, 32'd0, 1, 0, 0, ALU_ADD, 0, 0, 5, 1, 0, 0);
      tick();
      id_idle();
      set_mem(1, 0, 32'hFFFF_FFFF);
      set_wb(1, 0, 32'hFFFF_FFFF);
      #1 chk("x0_op1", operand1_o, 32'd0);
      set_mem(0, 0, 0);
      set_wb(0, 0, 0);

      // Load-use: LW x4, then ADD x5 = x4
      drive_id(1, 32'h300, 10, 0, 32'h80, 32'd0, 1, 0, 0, ALU_ADD, 0, 1, 4, 1, 1, 0);
      tick();
      chk("lw_rden", {31'd0, ex_mem_rden_o}, 32'd1);
      drive_id(1, 32'h304, 4, 0, 32'd0, 32'd0, 1, 0, 0, ALU_ADD, 0, 0, 5, 1, 0, 0);
      #1 chk("lu_stall", {31'd0, stall_o}, 32'd1);
      tick();
      chk("lu_bub_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("lu_bub_aluop", {28'd0, alu_op_o}, 32'd0);
      chk("lu_bub_rdwr",  {31'd0, ex_rd_wren_o}, 32'd0);
      set_mem(1, 4, 32'h80);
      #1 chk("lu_stall2", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
`ifdef EX_FWD_EN
      tick();
      set_mem(0, 0, 0);
      set_wb(1, 4, 32'h1234);
      #1;
`else
      tick();
      chk("lu_bub2_valid", {31'd0, ex_valid_o}, 32'd0);
      set_mem(0, 0, 0);
      set_wb(1, 4, 32'h1234);
      #1 chk("lu_stall3", {31'd0, stall_o}, 32'd0);
      tick();
      set_wb(0, 0, 0);
      #1;
`endif
      chk("lu_dep_valid", {31'd0, ex_valid_o}, 32'd1);
      chk("lu_dep_op1",   operand1_o, 32'h1234);
      set_wb(0, 0, 0);
      id_idle();

      // Flush coinciding with a load-use hazard
      drive_id(1, 32'h400, 10, 0, 32'h80, 32'd0, 1, 0, 0, ALU_ADD, 0, 1, 4, 1, 1, 0);
      tick();
      drive_id(1, 32'h404, 0, 4, 32'd0, 32'd0, 0, 1, 32'd8, ALU_ADD, 0, 1, 0, 0, 0, 1);
      flush_i = 1'b1;
      #1 chk("fl_stall", {31'd0, stall_o}, 32'd0);
      tick();
      flush_i = 1'b0;
      id_idle();
      chk("fl_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("fl_mwr",   {31'd0, ex_mem_wren_o}, 32'd0);

      // ADD x2 then dependent ADD immediately after
      drive_id(1, 32'h500, 1, 1, 32'd1, 32'd1, 1, 1, 0, ALU_ADD, 0, 0, 2, 1, 0, 0);
      tick();
      drive_id(1, 32'h504, 2, 0, 32'd0, 32'd0, 1, 0, 0, ALU_ADD, 0, 0, 3, 1, 0, 0);
      #1 chk("dep_stall1", {31'd0, stall_o}, FWD ? 32'd0 : 32'd1);
`ifdef EX_FWD_EN
      tick();
      id_idle();
      set_mem(1, 2, 32'h55);
      #1;
`else
      tick();
      set_mem(1, 2, 32'h55);
      #1 chk("dep_stall2", {31'd0, stall_o}, 32'd1);
      tick();
      chk("dep_bub_valid", {31'd0, ex_valid_o}, 32'd0);
      set_mem(0, 0, 0);
      set_wb(1, 2, 32'h55);
      #1 chk("dep_stall3", {31'd0, stall_o}, 32'd0);
      tick();
      set_wb(0, 0, 0);
      id_idle();
      #1;
`endif
      chk("dep_valid", {31'd0, ex_valid_o}, 32'd1);
      chk("dep_op1",   operand1_o, 32'h55);
      set_mem(0, 0, 0);

      // Asynchronous reset mid-stream
      drive_id(1, 32'h600, 1, 2, 32'd3, 32'd4, 1, 1, 0, ALU_SUB, 0, 0, 6, 1, 0, 0);
      tick();
      id_idle();
      chk("pre_rst_valid", {31'd0, ex_valid_o}, 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_valid", {31'd0, ex_valid_o}, 32'd0);
      chk("arst_aluop", {28'd0, alu_op_o}, 32'd0);
      chk("arst_rdwr",  {31'd0, ex_rd_wren_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
